// File: rtl/tnn_pkg.sv
// Shared types and helpers for the temporal neural network datapath blocks.
package tnn_pkg;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} enc_state_t;

   // Values at or beyond the last slot cannot produce a rising edge inside the cycle.
   function automatic logic val_is_inf(input int unsigned v, input int unsigned gamma);
      return v >= gamma - 1;
   endfunction

endpackage

// File: rtl/gamma_slot_counter.sv
// Gamma-cycle slot counter: IDLE/RUN control, slot count, boundary strobe and gamma_start pulse.
module gamma_slot_counter
   import tnn_pkg::*;
#(
   parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
   localparam int unsigned SLOT_W = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
   input  logic              aclk,
   input  logic              grst_n,
   input  logic              en,
   output logic [SLOT_W-1:0] slot_nxt,
   output logic              boundary,
   output logic              gamma_start
);

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(GAMMA_CYCLE_WIDTH - 1);

   enc_state_t        state;
   enc_state_t        state_nxt;
   logic [SLOT_W-1:0] slot;

   // boundary marks the edge that enters slot 0 of a running gamma cycle
   always_comb begin
      state_nxt = state;
      slot_nxt  = slot;
      boundary  = 1'b0;
      case (state)
         IDLE: begin
            slot_nxt = '0;
            if (en) begin
               state_nxt = RUN;
               boundary  = 1'b1;
            end
         end
         RUN: begin
            if (slot == LAST_SLOT) begin
               slot_nxt = '0;
               if (en) boundary  = 1'b1;
               else    state_nxt = IDLE;
            end else begin
               slot_nxt = slot + SLOT_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            slot_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge aclk or negedge grst_n) begin
      if (!grst_n) begin
         state       <= IDLE;
         slot        <= '0;
         gamma_start <= 1'b0;
      end else begin
         state       <= state_nxt;
         slot        <= slot_nxt;
         gamma_start <= boundary;
      end
   end

endmodule

// File: rtl/spike_time_encoder.sv
// Binary-to-temporal encoder: one spike per gamma cycle rising at slot 1+value.
// Build option SPIKE_STEP_EN selects step coding instead of fixed-width pulse coding.
module spike_time_encoder
   import tnn_pkg::*;
#(
   parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
   parameter int unsigned PULSE_WIDTH       = 8,
   localparam int unsigned VAL_W = $clog2(GAMMA_CYCLE_WIDTH)
) (
   input  logic             aclk,
   input  logic             grst_n,
   input  logic             en,
   input  logic             in_valid,
   input  logic [VAL_W-1:0] in_data,
   output logic             in_ready,
   output logic             gamma_start,
   output logic             spike,
   output logic             underrun
);

   localparam int unsigned SLOT_W = VAL_W + 1;

   logic [SLOT_W-1:0] slot_nxt;
   logic              boundary;
   logic [VAL_W-1:0]  pend;
   logic              pend_v;
   logic [VAL_W-1:0]  active;
   logic              xfer;
   logic              act_inf;
   logic [SLOT_W-1:0] rise;
   logic              spike_nxt;

   gamma_slot_counter #(
      .GAMMA_CYCLE_WIDTH(GAMMA_CYCLE_WIDTH)
   ) u_slot (
      .aclk        (aclk),
      .grst_n      (grst_n),
      .en          (en),
      .slot_nxt    (slot_nxt),
      .boundary    (boundary),
      .gamma_start (gamma_start)
   );

   assign in_ready = ~pend_v;
   assign xfer     = in_valid & ~pend_v;
   assign act_inf  = val_is_inf(32'(active), GAMMA_CYCLE_WIDTH);
   // One extra bit keeps 1+v from wrapping for the largest value
   assign rise     = SLOT_W'(active) + SLOT_W'(1);

`ifdef SPIKE_STEP_EN
   always_comb begin
      spike_nxt = (slot_nxt != '0) && !act_inf && (slot_nxt >= rise);
   end
`else
   logic [SLOT_W-1:0] pcnt;
   logic [SLOT_W-1:0] pcnt_nxt;

   // pcnt holds the remaining high cycles after the current one; slot 0 truncates
   always_comb begin
      spike_nxt = 1'b0;
      pcnt_nxt  = '0;
      if (slot_nxt != '0) begin
         if (!act_inf && (slot_nxt == rise)) begin
            spike_nxt = 1'b1;
            pcnt_nxt  = SLOT_W'(PULSE_WIDTH - 1);
         end else if (spike && (pcnt != '0)) begin
            spike_nxt = 1'b1;
            pcnt_nxt  = pcnt - SLOT_W'(1);
         end
      end
   end

   always_ff @(posedge aclk or negedge grst_n) begin
      if (!grst_n) pcnt <= '0;
      else         pcnt <= pcnt_nxt;
   end
`endif

   always_ff @(posedge aclk or negedge grst_n) begin
      if (!grst_n) begin
         pend_v   <= 1'b0;
         active   <= '1;
         spike    <= 1'b0;
         underrun <= 1'b0;
      end else begin
         if (xfer)          pend_v <= 1'b1;
         else if (boundary) pend_v <= 1'b0;
         if (boundary)      active <= pend_v ? pend : '1;
         underrun <= boundary & ~pend_v;
         spike    <= spike_nxt;
      end
   end

   always_ff @(posedge aclk) begin
      if (xfer) pend <= in_data;
   end

endmodule

// File: tb/tb_spike_time_encoder.sv
// Directed bench for spike_time_encoder (GAMMA_CYCLE_WIDTH=16, PULSE_WIDTH=8, pulse coding).
module tb_spike_time_encoder;

   logic       aclk = 1'b0;
   logic       grst_n;
   logic       en;
   logic       in_valid;
   logic [3:0] in_data;
   logic       in_ready;
   logic       gamma_start;
   logic       spike;
   logic       underrun;

   int n_tests = 0;
   int n_fail  = 0;

   spike_time_encoder #(
      .GAMMA_CYCLE_WIDTH(16),
      .PULSE_WIDTH(8)
   ) dut (
      .aclk        (aclk),
      .grst_n      (grst_n),
      .en          (en),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .gamma_start (gamma_start),
      .spike       (spike),
      .underrun    (underrun)
   );

   always #5 aclk = ~aclk;

   // One gamma cycle: expected underrun at slot 0, spike window [rise..last],
   // and what to offer during the cycle (0 none, 1 at slot 0, 2 at slot 15).
   typedef struct {
      logic       exp_ur;
      int         rise;
      int         last;
      int         mode;
      logic [3:0] nxt;
   } row_t;

   row_t vec[11];

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   initial begin
      int prev_mode;
      logic exp_rdy;

      vec[0]  = '{exp_ur: 1'b0, rise: 4,  last: 11, mode: 1, nxt: 4'd12};
      vec[1]  = '{exp_ur: 1'b0, rise: 13, last: 15, mode: 1, nxt: 4'd15};
      vec[2]  = '{exp_ur: 1'b0, rise: 16, last: 0,  mode: 1, nxt: 4'd0};
      vec[3]  = '{exp_ur: 1'b0, rise: 1,  last: 8,  mode: 1, nxt: 4'd4};
      vec[4]  = '{exp_ur: 1'b0, rise: 5,  last: 12, mode: 0, nxt: 4'd0};
      vec[5]  = '{exp_ur: 1'b1, rise: 16, last: 0,  mode: 1, nxt: 4'd7};
      vec[6]  = '{exp_ur: 1'b0, rise: 8,  last: 15, mode: 2, nxt: 4'd5};
      vec[7]  = '{exp_ur: 1'b1, rise: 16, last: 0,  mode: 0, nxt: 4'd0};
      vec[8]  = '{exp_ur: 1'b0, rise: 6,  last: 13, mode: 1, nxt: 4'd14};
      vec[9]  = '{exp_ur: 1'b0, rise: 15, last: 15, mode: 1, nxt: 4'd1};
      vec[10] = '{exp_ur: 1'b0, rise: 2,  last: 9,  mode: 1, nxt: 4'd9};

      grst_n   = 1'b0;
      en       = 1'b0;
      in_valid = 1'b0;
      in_data  = 4'd0;
      #22;
      chk("reset_in_ready", in_ready, 1'b1);
      chk("reset_gamma_start", gamma_start, 1'b0);
      chk("reset_spike", spike, 1'b0);
      chk("reset_underrun", underrun, 1'b0);
      @(negedge aclk);
      grst_n = 1'b1;

      // Preload value 3 while idle, then start running
      in_valid = 1'b1;
      in_data  = 4'd3;
      step();
      in_valid = 1'b0;
      chk("preload_ready_low", in_ready, 1'b0);
      chk("idle_gamma_start", gamma_start, 1'b0);
      en = 1'b1;
      step();

      prev_mode = 0;
      for (int r = 0; r < 11; r++) begin
         chk($sformatf("row%0d_s0_gamma_start", r), gamma_start, 1'b1);
         chk($sformatf("row%0d_s0_underrun", r), underrun, vec[r].exp_ur);
         chk($sformatf("row%0d_s0_spike", r), spike, 1'b0);
         chk($sformatf("row%0d_s0_in_ready", r), in_ready, (prev_mode != 2));
         for (int s = 1; s <= 16; s++) begin
            in_valid = (vec[r].mode == 1 && s == 1) || (vec[r].mode == 2 && s == 16);
            in_data  = vec[r].nxt;
            step();
            in_valid = 1'b0;
            if (s < 16) begin
               exp_rdy = (prev_mode != 2) && !(vec[r].mode == 1);
               chk($sformatf("row%0d_s%0d_spike", r, s), spike,
                   (s >= vec[r].rise) && (s <= vec[r].last));
               chk($sformatf("row%0d_s%0d_gamma_start", r, s), gamma_start, 1'b0);
               chk($sformatf("row%0d_s%0d_underrun", r, s), underrun, 1'b0);
               chk($sformatf("row%0d_s%0d_in_ready", r, s), in_ready, exp_rdy);
            end
         end
         prev_mode = vec[r].mode;
      end

      // Value 9 cycle; en drops at slot 5 but the cycle still completes
      chk("v9_s0_gamma_start", gamma_start, 1'b1);
      for (int s = 1; s <= 15; s++) begin
         step();
         chk($sformatf("v9_s%0d_spike", s), spike, (s >= 10));
         if (s == 5) en = 1'b0;
      end
      step();
      chk("idle_entry_gamma_start", gamma_start, 1'b0);
      chk("idle_entry_spike", spike, 1'b0);
      chk("idle_entry_underrun", underrun, 1'b0);
      chk("idle_entry_in_ready", in_ready, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("idle%0d_gamma_start", i), gamma_start, 1'b0);
      end

      // Restart with value 6, then reset asynchronously mid-spike at slot 7
      in_valid = 1'b1;
      in_data  = 4'd6;
      step();
      in_valid = 1'b0;
      en = 1'b1;
      step();
      chk("restart_gamma_start", gamma_start, 1'b1);
      chk("restart_underrun", underrun, 1'b0);
      in_valid = 1'b1;
      in_data  = 4'd2;
      step();
      in_valid = 1'b0;
      for (int s = 2; s <= 7; s++) step();
      chk("pre_reset_spike", spike, 1'b1);
      chk("pre_reset_in_ready", in_ready, 1'b0);
      #2;
      grst_n = 1'b0;
      #1;
      chk("async_reset_spike", spike, 1'b0);
      chk("async_reset_in_ready", in_ready, 1'b1);
      chk("async_reset_gamma_start", gamma_start, 1'b0);
      @(negedge aclk);
      grst_n = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
